// File: rtl/caf_pkg.sv
// caf_pkg: shared state encoding, default widths and sample type for the CAF
// peak-search datapath.
package caf_pkg;

    localparam int I_BITS     = 12;
    localparam int Q_BITS     = 12;
    localparam int INDEX_BITS = 4;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        STREAM,
        WAIT_RES
    } stream_state_t;

    typedef struct packed {
        logic signed [I_BITS-1:0] i;
        logic signed [Q_BITS-1:0] q;
    } iq_sample_t;

endpackage

// File: rtl/iq_frame_ram.sv
// iq_frame_ram: single-write-port frame store with a registered read port.
// A read of the address being written in the same cycle returns the new data.
module iq_frame_ram #(
    parameter int depth     = 10,
    parameter int addr_bits = 4,
    parameter int data_bits = 24
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [addr_bits-1:0] waddr,
    input  logic [data_bits-1:0] wdata,
    input  logic                 re,
    input  logic [addr_bits-1:0] raddr,
    output logic [data_bits-1:0] rdata
);

    logic [data_bits-1:0] mem [depth];

    // NOTE: the array has no reset so it maps onto block RAM; contents survive rst.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
        end
    end

endmodule

// File: rtl/iq_frame_streamer.sv
// iq_frame_streamer: streams a stored I/Q frame into arg_max and latches its result.
// Define IQ_STREAMER_LOOP_EN to re-stream the frame continuously until start is pulsed.
module iq_frame_streamer
    import caf_pkg::*;
#(
    parameter int buffer_length = 10,
    parameter int index_bits    = INDEX_BITS,
    parameter int out_max_bits  = 4,
    parameter int i_bits        = I_BITS,
    parameter int q_bits        = Q_BITS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [index_bits-1:0]   wr_addr,
    input  logic [i_bits-1:0]       wr_i,
    input  logic [q_bits-1:0]       wr_q,
    input  logic                    start,
    output logic                    busy,
    output logic                    m_axis_tvalid,
    output logic [i_bits-1:0]       xi,
    output logic [q_bits-1:0]       xq,
    input  logic                    s_axis_tready,
    output logic                    m_axis_tlast,
    input  logic                    res_valid,
    input  logic [out_max_bits-1:0] res_max,
    input  logic [index_bits:0]     res_index,
    output logic                    res_ready,
    output logic [out_max_bits-1:0] peak_max,
    output logic [index_bits:0]     peak_index,
    output logic                    done
);

    localparam int DATA_BITS = i_bits + q_bits;
    localparam int LAST_INT  = buffer_length - 1;
    localparam logic [index_bits:0] LEN  = buffer_length[index_bits:0];
    localparam logic [index_bits:0] LAST = LAST_INT[index_bits:0];

    stream_state_t state;

    logic [index_bits:0]  rd_ptr;
    logic [index_bits:0]  rd_addr;
    logic                 rd_en;
    logic [DATA_BITS-1:0] ram_rdata;
    logic                 rd_vld;
    logic                 rd_last;

    logic                 skid_vld;
    logic                 skid_last;
    logic [DATA_BITS-1:0] skid_data;
    logic                 skid_vld_nxt;

    logic                 wr_ok;
    logic                 xfer;
    logic                 out_load;
    logic                 res_take;
    logic                 restart;

`ifdef IQ_STREAMER_LOOP_EN
    logic                 stop_req;
`endif

    iq_frame_ram #(
        .depth     (buffer_length),
        .addr_bits (index_bits),
        .data_bits (DATA_BITS)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_addr),
        .wdata ({wr_i, wr_q}),
        .re    (rd_en),
        .raddr (rd_addr[index_bits-1:0]),
        .rdata (ram_rdata)
    );

    // NOTE: every signal below is assigned on every path, so no latch is inferred.
    always_comb begin
        wr_ok    = wr_en && (state == IDLE) && ({1'b0, wr_addr} < LEN);
        xfer     = m_axis_tvalid && s_axis_tready;
        out_load = !m_axis_tvalid || xfer;
        res_take = res_ready && res_valid;

        // Skid is occupied next cycle if it holds and cannot drain, or it refills
        // from the RAM because the output register is busy.
        if (skid_vld) begin
            skid_vld_nxt = !out_load || rd_vld;
        end else begin
            skid_vld_nxt = rd_vld && !out_load;
        end

`ifdef IQ_STREAMER_LOOP_EN
        restart = ((state == IDLE) && start) || (res_take && !stop_req && !start);
`else
        restart = (state == IDLE) && start;
`endif

        rd_en   = restart ||
                  (((state == PRIME) || (state == STREAM)) && (rd_ptr < LEN) && !skid_vld_nxt);
        rd_addr = restart ? '0 : rd_ptr;
    end

    // Read pointer, skid register and AXI-stream output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr        <= '0;
            rd_vld        <= 1'b0;
            rd_last       <= 1'b0;
            skid_vld      <= 1'b0;
            skid_last     <= 1'b0;
            skid_data     <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            xi            <= '0;
            xq            <= '0;
        end else begin
            rd_vld <= rd_en;
            if (rd_en) begin
                rd_ptr  <= rd_addr + 1'b1;
                rd_last <= (rd_addr == LAST);
            end

            if (out_load) begin
                if (skid_vld) begin
                    {xi, xq}      <= skid_data;
                    m_axis_tlast  <= skid_last;
                    m_axis_tvalid <= 1'b1;
                end else if (rd_vld) begin
                    {xi, xq}      <= ram_rdata;
                    m_axis_tlast  <= rd_last;
                    m_axis_tvalid <= 1'b1;
                end else begin
                    m_axis_tvalid <= 1'b0;
                end
            end

            skid_vld <= skid_vld_nxt;
            // RAM data lands in the skid when the skid drains into the output
            // (refill) or when the output stalls with the skid empty (capture).
            if (rd_vld && (skid_vld == out_load)) begin
                skid_data <= ram_rdata;
                skid_last <= rd_last;
            end
        end
    end

    // NOTE: state and registered outputs use <= so all see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            res_ready  <= 1'b0;
            done       <= 1'b0;
            peak_max   <= '0;
            peak_index <= '0;
`ifdef IQ_STREAMER_LOOP_EN
            stop_req   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef IQ_STREAMER_LOOP_EN
            if (start && (state != IDLE)) begin
                stop_req <= 1'b1;
            end
            if (res_take) begin
                stop_req <= 1'b0;
            end
`endif
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= PRIME;
                        busy  <= 1'b1;
                    end
                end
                PRIME: begin
                    state <= STREAM;
                end
                STREAM: begin
                    if (xfer && m_axis_tlast) begin
                        state     <= WAIT_RES;
                        res_ready <= 1'b1;
                    end
                end
                WAIT_RES: begin
                    if (res_take) begin
                        peak_max   <= res_max;
                        peak_index <= res_index;
                        done       <= 1'b1;
                        res_ready  <= 1'b0;
                        if (restart) begin
                            state <= PRIME;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iq_frame_streamer.sv
// tb_iq_frame_streamer: directed self-checking bench for iq_frame_streamer.
// Build with IQ_STREAMER_LOOP_EN defined to exercise continuous re-streaming.
module tb_iq_frame_streamer;
    import caf_pkg::*;

    localparam int LEN = 10;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [11:0] wr_i;
    logic [11:0] wr_q;
    logic        start;
    logic        busy;
    logic        m_axis_tvalid;
    logic [11:0] xi;
    logic [11:0] xq;
    logic        s_axis_tready;
    logic        m_axis_tlast;
    logic        res_valid;
    logic [3:0]  res_max;
    logic [4:0]  res_index;
    logic        res_ready;
    logic [3:0]  peak_max;
    logic [4:0]  peak_index;
    logic        done;

    int errors = 0;
    int checks = 0;

    iq_sample_t exp_frame [LEN];
    logic [3:0] last_max;
    logic [4:0] last_idx;
    bit         tr_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    iq_frame_streamer dut (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_i          (wr_i),
        .wr_q          (wr_q),
        .start         (start),
        .busy          (busy),
        .m_axis_tvalid (m_axis_tvalid),
        .xi            (xi),
        .xq            (xq),
        .s_axis_tready (s_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .res_valid     (res_valid),
        .res_max       (res_max),
        .res_index     (res_index),
        .res_ready     (res_ready),
        .peak_max      (peak_max),
        .peak_index    (peak_index),
        .done          (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_i = '0; wr_q = '0;
        start = 1'b0; s_axis_tready = 1'b1;
        res_valid = 1'b0; res_max = '0; res_index = '0;
        last_max = '0; last_idx = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || res_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: tvalid=%b busy=%b done=%b res_ready=%b, expected all 0",
                     m_axis_tvalid, busy, done, res_ready);
        end
        checks++;
        if (xi !== 12'd0 || xq !== 12'd0 || m_axis_tlast !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: xi=%0h xq=%0h tlast=%b, expected 0", xi, xq, m_axis_tlast);
        end
        checks++;
        if (peak_max !== 4'd0 || peak_index !== 5'd0) begin
            errors++;
            $display("FAIL reset_peak: peak_max=%0d peak_index=%0d, expected 0", peak_max, peak_index);
        end
        #2 rst = 1'b0;
        tick();
    endtask

    task automatic load_frame();
        for (int k = 0; k < LEN; k++) begin
            wr_en = 1'b1; wr_addr = 4'(k); wr_i = 12'(k); wr_q = 12'(-k);
            exp_frame[k].i = 12'(k);
            exp_frame[k].q = 12'(-k);
            tick();
        end
        wr_en = 1'b0;
    endtask

    // Pulses start (together with any write already set up) and checks PRIME.
    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        checks++;
        if (m_axis_tvalid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_prime: tvalid=%b busy=%b, expected tvalid=0 busy=1", m_axis_tvalid, busy);
        end
    endtask

    // Entered with the DUT in PRIME. mode 0: tready high, transfer k expected at
    // cycle k+1. mode 1: tready follows 1,0,0,1. inject: start, a write and a
    // premature result are driven mid-stream and must all be ignored.
    task automatic stream_frame(input int mode, input bit inject);
        int          k;
        int          cyc;
        bit          stalled;
        bit          bad_done;
        logic [11:0] prev_i;
        logic [11:0] prev_q;
        logic        prev_last;
        k = 0; cyc = 0; stalled = 1'b0; bad_done = 1'b0;
        prev_i = '0; prev_q = '0; prev_last = 1'b0;
        while (k < LEN && cyc < 200) begin
            if (cyc >= 1 && done !== 1'b0) bad_done = 1'b1;
            if (stalled) begin
                checks++;
                if (m_axis_tvalid !== 1'b1 || xi !== prev_i || xq !== prev_q || m_axis_tlast !== prev_last) begin
                    errors++;
                    $display("FAIL stall_hold cyc %0d: tvalid=%b xi=%0h xq=%0h tlast=%b, expected 1 %0h %0h %b",
                             cyc, m_axis_tvalid, xi, xq, m_axis_tlast, prev_i, prev_q, prev_last);
                end
            end
            s_axis_tready = (mode == 0) ? 1'b1 : tr_pat[cyc % 4];
            start     = inject && (cyc == 3);
            wr_en     = inject && (cyc == 3);
            wr_addr   = 4'd4; wr_i = 12'd100; wr_q = 12'd100;
            res_valid = inject;
            res_max   = 4'd15; res_index = 5'd31;
            if (m_axis_tvalid && s_axis_tready) begin
                checks++;
                if (xi !== exp_frame[k].i || xq !== exp_frame[k].q || m_axis_tlast !== (k == LEN - 1) ||
                    (mode == 0 && cyc != k + 1)) begin
                    errors++;
                    $display("FAIL sample %0d: xi=%0h xq=%0h tlast=%b cyc=%0d, expected xi=%0h xq=%0h tlast=%b",
                             k, xi, xq, m_axis_tlast, cyc, exp_frame[k].i, exp_frame[k].q, (k == LEN - 1));
                end
                k++;
            end
            stalled   = m_axis_tvalid && !s_axis_tready;
            prev_i    = xi; prev_q = xq; prev_last = m_axis_tlast;
            tick();
            cyc++;
        end
        start = 1'b0; wr_en = 1'b0; res_valid = 1'b0; s_axis_tready = 1'b1;
        checks++;
        if (k != LEN) begin
            errors++;
            $display("FAIL transfer_count: got %0d transfers, expected %0d", k, LEN);
        end
        checks++;
        if (m_axis_tvalid !== 1'b0 || res_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL wait_res_entry: tvalid=%b res_ready=%b busy=%b, expected 0 1 1",
                     m_axis_tvalid, res_ready, busy);
        end
        checks++;
        if (bad_done || peak_max !== last_max || peak_index !== last_idx) begin
            errors++;
            $display("FAIL early_result: stray_done=%b peak=%0d/%0d, expected no done and peak %0d/%0d",
                     bad_done, peak_max, peak_index, last_max, last_idx);
        end
    endtask

    task automatic take_result(input logic [3:0] mx, input logic [4:0] ix, input int delay,
                               input bit exp_busy, input bit loop_next);
        for (int d = 0; d < delay; d++) begin
            checks++;
            if (res_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL res_wait %0d: res_ready=%b done=%b busy=%b, expected 1 0 1",
                         d, res_ready, done, busy);
            end
            tick();
        end
        res_valid = 1'b1; res_max = mx; res_index = ix;
        tick();
        res_valid = 1'b0; res_max = '0; res_index = '0;
        last_max = mx; last_idx = ix;
        checks++;
        if (done !== 1'b1 || peak_max !== mx || peak_index !== ix || busy !== exp_busy || res_ready !== 1'b0) begin
            errors++;
            $display("FAIL result_latch: done=%b peak=%0d/%0d busy=%b res_ready=%b, expected 1 %0d/%0d %b 0",
                     done, peak_max, peak_index, busy, res_ready, mx, ix, exp_busy);
        end
        if (!loop_next) begin
            tick();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || peak_max !== mx || peak_index !== ix) begin
                errors++;
                $display("FAIL result_hold: done=%b busy=%b peak=%0d/%0d, expected 0 0 %0d/%0d",
                         done, busy, peak_max, peak_index, mx, ix);
            end
        end
    endtask

    task automatic test_stream_full();
        do_start();
        stream_frame(0, 1'b0);
        take_result(4'd7, 5'd3, 3, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        do_start();
        stream_frame(1, 1'b0);
        take_result(4'd12, 5'd9, 0, 1'b0, 1'b0);
    endtask

    task automatic test_write_blocking();
        do_start();
        stream_frame(0, 1'b1);
        take_result(4'd5, 5'd17, 1, 1'b0, 1'b0);
        wr_en = 1'b1; wr_addr = 4'd12; wr_i = 12'd100; wr_q = 12'd100;
        tick();
        wr_en = 1'b0;
        do_start();
        stream_frame(0, 1'b0);
        take_result(4'd1, 5'd0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_write_with_start();
        wr_en = 1'b1; wr_addr = 4'd0; wr_i = 12'd50; wr_q = 12'(-50);
        exp_frame[0].i = 12'd50;
        exp_frame[0].q = 12'(-50);
        do_start();
        stream_frame(0, 1'b0);
        take_result(4'd15, 5'd9, 0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_midstream();
        int n;
        do_start();
        n = 0;
        while (!(m_axis_tvalid === 1'b1 && xi === exp_frame[5].i) && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL reach_sample5: sample 5 not seen within 20 cycles, xi=%0h", xi);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL async_abort: tvalid=%b busy=%b done=%b, expected all 0", m_axis_tvalid, busy, done);
        end
        #1 rst = 1'b0;
        last_max = '0; last_idx = '0;
        tick();
        checks++;
        if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || peak_max !== 4'd0) begin
            errors++;
            $display("FAIL post_reset_idle: tvalid=%b busy=%b done=%b peak_max=%0d, expected all 0",
                     m_axis_tvalid, busy, done, peak_max);
        end
        do_start();
        stream_frame(0, 1'b0);
        take_result(4'd3, 5'd2, 0, 1'b0, 1'b0);
    endtask

`ifdef IQ_STREAMER_LOOP_EN
    task automatic test_loop();
        do_start();
        for (int f = 0; f < 3; f++) begin
            stream_frame(0, f == 2);
            take_result(4'(f + 1), 5'(f + 4), 1, f < 2, f < 2);
        end
        repeat (3) tick();
        checks++;
        if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || res_ready !== 1'b0) begin
            errors++;
            $display("FAIL loop_stop: tvalid=%b busy=%b done=%b res_ready=%b, expected all 0",
                     m_axis_tvalid, busy, done, res_ready);
        end
    endtask
`endif

    initial begin
        test_reset();
        load_frame();
`ifdef IQ_STREAMER_LOOP_EN
        test_loop();
`else
        test_stream_full();
        test_stall();
        test_write_blocking();
        test_write_with_start();
        test_reset_midstream();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
